// File: rtl/conv_acc_relu_requant.sv
// Accumulates TAP_COUNT signed products plus a per-window bias, then rounds,
// shifts, applies ReLU and saturates to an unsigned-range activation.
module conv_acc_relu_requant #(
  parameter int PROD_W    = 22,
  parameter int BIAS_W    = 14,
  parameter int ACC_W     = 32,
  parameter int TAP_COUNT = 9,
  parameter int SHIFT     = 6,
  parameter int OUT_W     = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [BIAS_W-1:0] bias_in,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CNT_W = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAP_COUNT - 1);
  localparam logic signed [ACC_W:0] RND_HALF = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] ACT_MAX  = (ACC_W+1)'((1 << (OUT_W-1)) - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FINAL = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // One extra bit keeps the rounding add from wrapping at the accumulator's top.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'(acc) + RND_HALF;
    return sum >>> SHIFT;
  endfunction

  // Returns {sat, data}: negatives clamp to zero, large values clip to ACT_MAX.
  function automatic logic [OUT_W:0] relu_sat(input logic signed [ACC_W:0] r);
    if (r[ACC_W])
      return '0;
    else if (r > ACT_MAX)
      return {1'b1, OUT_W'(ACT_MAX)};
    else
      return {1'b0, r[OUT_W-1:0]};
  endfunction

  state_e                    state_q,     state_d;
  logic [CNT_W-1:0]          tap_cnt_q,   tap_cnt_d;
  logic signed [ACC_W-1:0]   acc_q,       acc_d;
  logic [OUT_W-1:0]          out_data_q,  out_data_d;
  logic                      out_sat_q,   out_sat_d;
  logic                      out_valid_q, out_valid_d;
  logic                      accept;

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    prod_ready  = (state_q == ST_ACCUM);
    accept      = prod_valid && prod_ready;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (tap_cnt_q == '0)
            acc_d = ACC_W'(bias_in) + ACC_W'(prod_data);
          else
            acc_d = acc_q + ACC_W'(prod_data);
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = '0;
            state_d   = ST_FINAL;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINAL: begin
        {out_sat_d, out_data_d} = relu_sat(round_shift(acc_q));
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_ACCUM;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_acc_relu_requant.sv
// Scoreboard bench: windows are issued with random gaps and backpressure while
// a monitor pops expected activations from a reference model.
module tb_conv_acc_relu_requant;

  localparam int PROD_W = 22;
  localparam int BIAS_W = 14;
  localparam int TC     = 9;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 8;
  localparam longint ACT_MAX = (64'sd1 <<< (OUT_W-1)) - 1;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [BIAS_W-1:0] bias_in;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sink_mode = 0;   // 0: always ready, 1: random, 2: stall
  logic [OUT_W:0] sb_q[$];
  int cur_taps[TC];

  conv_acc_relu_requant dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .bias_in   (bias_in),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired, got timeout, expected event", name);
  endtask

  // Reference: exact integer sum, round half up, floor division by 2^SHIFT, clip.
  function automatic logic [OUT_W:0] model(input int bias);
    longint acc, num, den, r;
    acc = bias;
    for (int i = 0; i < TC; i++) acc += cur_taps[i];
    den = 64'sd1 <<< SHIFT;
    num = acc + den / 2;
    r = num / den;
    if ((num % den != 0) && (num < 0)) r = r - 1;
    if (r < 0) return '0;
    if (r > ACT_MAX) return {1'b1, OUT_W'(ACT_MAX)};
    return {1'b0, OUT_W'(r)};
  endfunction

  task automatic drive_tap(input int b, input int p);
    int n;
    prod_valid = 1'b1;
    prod_data  = PROD_W'(p);
    bias_in    = BIAS_W'(b);
    n = 0;
    @(negedge ap_clk);
    while (!prod_ready && n < 500) begin
      @(negedge ap_clk);
      n++;
    end
    if (!prod_ready) fail_now("tap_accept");
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    prod_data  = PROD_W'($urandom);
    bias_in    = BIAS_W'($urandom);
  endtask

  task automatic send_window(input int bias, input bit gaps, input bit chk_lat);
    sb_q.push_back(model(bias));
    for (int i = 0; i < TC; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge ap_clk); #1; end
      drive_tap((i == 0) ? bias : (int'($urandom) >>> 18), cur_taps[i]);
    end
    if (chk_lat) begin
      check("latency_final_cycle", out_valid, 0);
      @(posedge ap_clk);
      #1;
      check("latency_valid_at_n2", out_valid, 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n >= 500) fail_now("drain");
  endtask

  task automatic fill_taps(input int v);
    for (int i = 0; i < TC; i++) cur_taps[i] = v;
  endtask

  // Sink: owns out_ready.
  initial begin : sink
    out_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every output handshake and checks hold-stability.
  initial begin : monitor
    logic             held;
    logic [OUT_W-1:0] prev_d;
    logic             prev_s;
    logic [OUT_W:0]   exp;
    held = 1'b0;
    prev_d = '0;
    prev_s = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && out_valid) begin
        check("prod_ready_low_in_out", prod_ready, 0);
        if (held) begin
          check("hold_data", out_data, prev_d);
          check("hold_sat", out_sat, prev_s);
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            exp = sb_q.pop_front();
            check("out_data", out_data, exp[OUT_W-1:0]);
            check("out_sat", out_sat, exp[OUT_W]);
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          prev_d = out_data;
          prev_s = out_sat;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [OUT_W-1:0] cap_d;
    logic             cap_s;
    int               n;
    ap_rst_n   = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias_in    = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_prod_ready", prod_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    fill_taps(64);
    send_window(0, 1'b0, 1'b1);
    wait_drain();

    fill_taps(-100);
    send_window(-100, 1'b0, 1'b0);
    fill_taps(2000);
    send_window(0, 1'b0, 1'b0);
    fill_taps(-(1 << 21));
    send_window(0, 1'b0, 1'b0);
    fill_taps(0); cur_taps[0] = 32;
    send_window(0, 1'b0, 1'b0);
    fill_taps(0); cur_taps[0] = 31;
    send_window(0, 1'b0, 1'b0);
    fill_taps(0);
    send_window(64, 1'b0, 1'b0);
    wait_drain();

    // Output stall: five cycles of out_ready low.
    sink_mode = 2;
    @(posedge ap_clk);
    #1;
    fill_taps(2000);
    send_window(0, 1'b1, 1'b0);
    n = 0;
    @(negedge ap_clk);
    while (!out_valid && n < 100) begin @(negedge ap_clk); n++; end
    if (!out_valid) fail_now("stall_valid");
    cap_d = out_data;
    cap_s = out_sat;
    repeat (5) begin
      @(negedge ap_clk);
      check("stall_data", out_data, cap_d);
      check("stall_sat", out_sat, cap_s);
      check("stall_prod_ready", prod_ready, 0);
    end
    sink_mode = 0;
    n = 0;
    @(posedge ap_clk);
    #1;
    while (out_valid && n < 100) begin @(posedge ap_clk); #1; n++; end
    if (out_valid) fail_now("stall_release");
    check("ready_after_handshake", prod_ready, 1);
    wait_drain();

    // Async reset in the middle of a window.
    for (int i = 0; i < 4; i++) drive_tap((i == 0) ? 500 : 0, 1000);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    fill_taps(64);
    send_window(0, 1'b0, 1'b1);
    wait_drain();

    // Randomized windows with gaps and random downstream readiness.
    sink_mode = 1;
    for (int w = 0; w < 40; w++) begin
      for (int i = 0; i < TC; i++) begin
        if ($urandom_range(0, 1) == 0) cur_taps[i] = int'($urandom) >>> 10;
        else                           cur_taps[i] = $urandom_range(0, 600) - 200;
      end
      send_window(int'($urandom) >>> 18, 1'($urandom), 1'b0);
    end
    sink_mode = 0;
    wait_drain();
    check("scoreboard_empty", sb_q.size(), 0);

    repeat (3) @(posedge ap_clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
